// File: rtl/game_phase_sequencer_if.sv
// Signal bundle between the game phase sequencer and the rest of the game:
// frame/control inputs in, screen phase, lives and game-logic gating out.
interface game_phase_sequencer_if;
    logic       frame_tick;
    logic       start_btn;
    logic       mario_alive;
    logic       level_done;
    logic [3:0] phase;
    logic [2:0] lives;
    logic       game_run;
    logic       game_reset;

    modport master (
        output frame_tick,
        output start_btn,
        output mario_alive,
        output level_done,
        input  phase,
        input  lives,
        input  game_run,
        input  game_reset
    );

    modport slave (
        input  frame_tick,
        input  start_btn,
        input  mario_alive,
        input  level_done,
        output phase,
        output lives,
        output game_run,
        output game_reset
    );
endinterface

// File: rtl/game_phase_sequencer.sv
// Top-level game flow controller: sequences start/intro/play/death/end screens,
// owns the lives counter and frame-based phase timers, and gates game logic.
module game_phase_sequencer #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned INTRO_FRAMES = 120,
    parameter int unsigned DEATH_FRAMES = 90,
    parameter int unsigned END_FRAMES   = 300
) (
    input  logic                   Clk,
    input  logic                   RESET,
    game_phase_sequencer_if.slave  bus
);

    localparam logic [2:0] LivesInit = 3'(LIVES_INIT);
    localparam logic [8:0] IntroLast = 9'(INTRO_FRAMES - 1);
    localparam logic [8:0] DeathLast = 9'(DEATH_FRAMES - 1);
    localparam logic [8:0] EndLast   = 9'(END_FRAMES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIntro,
        StPlay,
        StDying,
        StGameover,
        StWin
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [8:0] fcnt_q, fcnt_d;
    logic       start_prev_q;
    logic       game_reset_q, game_reset_d;

    logic       start_rise;
    logic       counting;
    logic [8:0] frame_last;
    logic       timer_done;

    // start_prev resets high so a key held through reset never starts a game.
    assign start_rise = bus.start_btn & ~start_prev_q;

    assign counting = (state_q == StIntro) || (state_q == StDying) ||
                      (state_q == StGameover) || (state_q == StWin);

    always_comb begin
        frame_last = '0;
        unique case (state_q)
            StIntro:           frame_last = IntroLast;
            StDying:           frame_last = DeathLast;
            StGameover, StWin: frame_last = EndLast;
            default:           frame_last = '0;
        endcase
    end

    assign timer_done = counting && bus.frame_tick && (fcnt_q == frame_last);

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d = StIntro;
                    lives_d = LivesInit;
                end
            end
            StIntro: begin
                if (timer_done) state_d = StPlay;
            end
            StPlay: begin
                // Death takes priority over reaching the goal in the same cycle.
                if (!bus.mario_alive) begin
                    state_d = StDying;
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                end else if (bus.level_done) begin
                    state_d = StWin;
                end
            end
            StDying: begin
                if (timer_done) state_d = (lives_q == 3'd0) ? StGameover : StIntro;
            end
            StGameover, StWin: begin
                if (timer_done || start_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (state_d != state_q) begin
            fcnt_d = '0;
        end else if (counting && bus.frame_tick) begin
            fcnt_d = fcnt_q + 9'd1;
        end
    end

    // Pulse on the first cycle of every INTRO entry (new game and respawn).
    assign game_reset_d = (state_d == StIntro) && (state_q != StIntro);

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state_q      <= StIdle;
            lives_q      <= LivesInit;
            fcnt_q       <= '0;
            start_prev_q <= 1'b1;
            game_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            fcnt_q       <= fcnt_d;
            start_prev_q <= bus.start_btn;
            game_reset_q <= game_reset_d;
        end
    end

    always_comb begin
        bus.phase = 4'b1000;
        unique case (state_q)
            StIdle:                   bus.phase = 4'b1000;
            StIntro, StPlay, StDying: bus.phase = 4'b0100;
            StGameover:               bus.phase = 4'b0010;
            StWin:                    bus.phase = 4'b0001;
            default:                  bus.phase = 4'b1000;
        endcase
    end

    assign bus.lives      = lives_q;
    assign bus.game_run   = (state_q == StPlay);
    assign bus.game_reset = game_reset_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed self-checking bench for game_phase_sequencer with short phase timers.
module tb_game_phase_sequencer;

    localparam int unsigned IntroN = 4;
    localparam int unsigned DeathN = 3;
    localparam int unsigned EndN   = 5;

    logic Clk;
    logic RESET;
    int   n_tests;
    int   n_fail;

    game_phase_sequencer_if bus ();

    game_phase_sequencer #(
        .LIVES_INIT  (3),
        .INTRO_FRAMES(IntroN),
        .DEATH_FRAMES(DeathN),
        .END_FRAMES  (EndN)
    ) dut (
        .Clk  (Clk),
        .RESET(RESET),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns 1 ns after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
    endtask

    task automatic run_intro();
        for (int i = 0; i < int'(IntroN); i++) tick();
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        RESET            = 1'b1;
        bus.frame_tick   = 1'b0;
        bus.start_btn    = 1'b1;
        bus.mario_alive  = 1'b1;
        bus.level_done   = 1'b0;

        #2 RESET = 1'b0;
        #1;
        check("rst_phase", 32'(bus.phase), 32'h8);
        check("rst_lives", 32'(bus.lives), 32'd3);
        check("rst_run", 32'(bus.game_run), 32'd0);
        check("rst_greset", 32'(bus.game_reset), 32'd0);
        step();
        RESET = 1'b1;

        // Key held through reset must not start a game.
        for (int i = 0; i < 10; i++) step();
        check("held_idle", 32'(bus.phase), 32'h8);
        bus.start_btn = 1'b0;
        step();
        check("released_idle", 32'(bus.phase), 32'h8);
        press_start();
        check("start_phase", 32'(bus.phase), 32'h4);
        check("start_greset", 32'(bus.game_reset), 32'd1);
        check("start_lives", 32'(bus.lives), 32'd3);
        check("start_run", 32'(bus.game_run), 32'd0);
        step();
        check("greset_one_cycle", 32'(bus.game_reset), 32'd0);

        // Intro length: game_run rises only on the edge sampling the 4th tick.
        for (int i = 0; i < int'(IntroN) - 1; i++) tick();
        check("intro_not_yet", 32'(bus.game_run), 32'd0);
        tick();
        check("intro_done_run", 32'(bus.game_run), 32'd1);
        tick();
        check("play_ignores_tick", 32'(bus.game_run), 32'd1);

        // Three deaths: 3->2->1->0, respawn twice, then game over.
        for (int d = 0; d < 3; d++) begin
            bus.mario_alive = 1'b0;
            step();
            bus.mario_alive = 1'b1;
            check("death_lives", 32'(bus.lives), 32'(2 - d));
            check("death_phase", 32'(bus.phase), 32'h4);
            check("death_run", 32'(bus.game_run), 32'd0);
            for (int i = 0; i < int'(DeathN) - 1; i++) tick();
            check("dying_hold", 32'(bus.game_reset), 32'd0);
            tick();
            if (d < 2) begin
                check("respawn_greset", 32'(bus.game_reset), 32'd1);
                check("respawn_phase", 32'(bus.phase), 32'h4);
                run_intro();
                check("respawn_play", 32'(bus.game_run), 32'd1);
            end else begin
                check("gameover_phase", 32'(bus.phase), 32'h2);
                check("gameover_greset", 32'(bus.game_reset), 32'd0);
                check("gameover_lives", 32'(bus.lives), 32'd0);
            end
        end

        // Game over screen held exactly END_FRAMES ticks without a press.
        for (int i = 0; i < int'(EndN) - 1; i++) tick();
        check("end_hold", 32'(bus.phase), 32'h2);
        tick();
        check("end_expire", 32'(bus.phase), 32'h8);

        // Death and goal in the same cycle: death wins.
        press_start();
        check("newgame_lives", 32'(bus.lives), 32'd3);
        check("newgame_greset", 32'(bus.game_reset), 32'd1);
        run_intro();
        bus.mario_alive = 1'b0;
        bus.level_done  = 1'b1;
        step();
        bus.mario_alive = 1'b1;
        bus.level_done  = 1'b0;
        check("tie_phase", 32'(bus.phase), 32'h4);
        check("tie_lives", 32'(bus.lives), 32'd2);
        check("tie_run", 32'(bus.game_run), 32'd0);
        for (int i = 0; i < int'(DeathN); i++) tick();
        run_intro();
        check("tie_replay", 32'(bus.game_run), 32'd1);

        // Win, then an early start press returns to IDLE.
        bus.level_done = 1'b1;
        step();
        bus.level_done = 1'b0;
        check("win_phase", 32'(bus.phase), 32'h1);
        check("win_run", 32'(bus.game_run), 32'd0);
        check("win_lives", 32'(bus.lives), 32'd2);
        tick();
        tick();
        check("win_hold", 32'(bus.phase), 32'h1);
        press_start();
        check("win_early_exit", 32'(bus.phase), 32'h8);

        // Asynchronous reset mid-DYING.
        step();
        press_start();
        run_intro();
        bus.mario_alive = 1'b0;
        step();
        bus.mario_alive = 1'b1;
        check("pre_abort_lives", 32'(bus.lives), 32'd2);
        #2 RESET = 1'b0;
        #1;
        check("abort_phase", 32'(bus.phase), 32'h8);
        check("abort_lives", 32'(bus.lives), 32'd3);
        check("abort_run", 32'(bus.game_run), 32'd0);
        check("abort_greset", 32'(bus.game_reset), 32'd0);
        step();
        RESET = 1'b1;
        step();
        check("post_abort_idle", 32'(bus.phase), 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_phase_sequencer.md
# game_phase_sequencer

Top-level game flow controller for the Mario final project. It sequences the screen phase (start, level intro, play, death, game over, win), owns the lives counter and frame-based phase timers, and gates the game logic. Its one-hot `phase` output drives the screen/sprite multiplexer. `game_run` and `game_reset` drive the level, physics and enemy logic.

## Interface
- `LIVES_INIT`, default 3: lives loaded at game start; legal range 1..7.
- `INTRO_FRAMES`, default 120: frames the intro lasts before play begins; legal range 1..511.
- `DEATH_FRAMES`, default 90: frames the death animation lasts; legal range 1..511.
- `END_FRAMES`, default 300: frames the game-over or win screen is held; legal range 1..511.

- `Clk` in 1: system clock; all state changes on its rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per VGA frame (vsync).
- `start_btn` in 1: start key, already synchronized to `Clk`, level-sensitive.
- `mario_alive` in 1: 0 means Mario died this cycle or earlier.
- `level_done` in 1: 1 means the flag/goal was reached.
- `phase` out 4: one-hot screen select.
  - 1000 = start screen.
  - 0100 = game screen.
  - 0010 = game-over screen.
  - 0001 = win screen.
- `lives` out 3: remaining lives.
- `game_run` out 1: 1 enables game-logic updates.
- `game_reset` out 1: one-cycle pulse that reinitializes the level.

## Operation
- States: IDLE, INTRO, PLAY, DYING, GAMEOVER, WIN.
- Outputs are Moore, decoded from the state register:
  - `phase`: IDLE → 1000; INTRO, PLAY and DYING → 0100; GAMEOVER → 0010; WIN → 0001.
  - `game_run`: 1 only in PLAY.
- Start detect: `start_rise` = `start_btn` & ~`start_prev`, where `start_prev` is a register that resets to 1. A key held through reset therefore does not start a game; it must be released and pressed again.
- Frame counter `fcnt` is 9 bits. It clears on every state change and increments on each `frame_tick` while in INTRO, DYING, GAMEOVER or WIN. "Timer expires" means `frame_tick`=1 while `fcnt` = N-1, where N is that state's `*_FRAMES` parameter.
- Transitions:
  - IDLE → INTRO on `start_rise`. Load `lives` ← `LIVES_INIT`.
  - INTRO → PLAY on INTRO_FRAMES timer expiry.
  - PLAY → DYING when `mario_alive`=0. Decrement `lives` (saturates at 0).
  - PLAY → WIN when `mario_alive`=1 and `level_done`=1. If `mario_alive`=0 and `level_done`=1 in the same cycle, death wins and the next state is DYING.
  - DYING → GAMEOVER on DEATH_FRAMES expiry when `lives`=0.
  - DYING → INTRO on DEATH_FRAMES expiry when `lives`>0 (respawn).
  - GAMEOVER and WIN → IDLE on END_FRAMES expiry, or earlier on `start_rise`, whichever comes first.
- `game_reset` is registered. It is high for exactly the first cycle in INTRO on every entry (new game and respawn). It is 0 at all other times.
- `mario_alive` and `level_done` are ignored outside PLAY.
- `frame_tick` is ignored in IDLE and PLAY.

## Timing
- Reset (`RESET`=0, asynchronous) immediately forces:
  - state = IDLE, `phase` = 1000, `lives` = `LIVES_INIT`;
  - `game_run` = 0, `game_reset` = 0, `fcnt` = 0, `start_prev` = 1.
- Reset asserted mid-game aborts any phase immediately. Release is synchronous to `Clk`; the first transition is possible on the edge after release.
- Latency: an input condition sampled at edge k changes the state and all Moore outputs at edge k. `game_reset` is high from edge k to edge k+1.
- Phase durations are measured in `frame_tick` pulses:
  - INTRO lasts exactly `INTRO_FRAMES` ticks.
  - PLAY is entered on the edge that samples the INTRO_FRAMES-th tick.
- A `frame_tick` coinciding with a state entry is not counted, because `fcnt` clears on the state change.
- `lives` changes only on PLAY→DYING (decrement) and IDLE→INTRO (load).

## Test plan
- Reset with `start_btn`=1 held, then keep it held for 10 cycles → state stays IDLE, `phase`=1000. Release, then press → `phase`=0100 and `game_reset` high for exactly 1 cycle, `lives`=3.
- `INTRO_FRAMES`=4: from INTRO entry, issue 4 `frame_tick` pulses → `game_run` rises on the edge sampling the 4th tick, not earlier.
- In PLAY, drop `mario_alive` → `lives` 3→2, state DYING. After `DEATH_FRAMES` ticks → INTRO with a `game_reset` pulse. Repeat until `lives`=0 → `phase`=0010 after the final death timer.
- In PLAY, assert `mario_alive`=0 and `level_done`=1 in the same cycle → DYING, not WIN; `lives` decrements.
- In PLAY with `mario_alive`=1, pulse `level_done` → `phase`=0001, `game_run`=0. A `start_rise` before `END_FRAMES` → IDLE, `phase`=1000. A separate run with no press returns to IDLE after exactly `END_FRAMES` ticks.
- Assert `RESET` low mid-DYING → outputs immediately read `phase`=1000, `lives`=3, `game_run`=0.
